dmem_bus_bridge: RTL and testbench

- Sits directly downstream of the load/store unit, in place of the ideal single-cycle data memory.
- Takes the LSU's word-aligned access (active-low chip select, active-low write enable, byte mask, address, write data) and converts it into a req/gnt/rvalid handshake to a data memory with variable latency.
- Returns load data on data_rd.
- Drives a stall line that freezes the core until the access completes, with a timeout so a dead memory cannot hang the core.

---
 rtl/dmem_bus_bridge.sv | 128 ++++++++++++
 tb/tb_dmem_bus_bridge.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_bridge.sv
// Bridges the LSU's single-cycle data-memory port onto a req/gnt/rvalid memory bus.
// Freezes the core with stall until the access completes or times out.
`timescale 1ns/1ps
module dmem_bus_bridge #(
  parameter int unsigned TIMEOUT   = 64,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic        wr,
  input  logic [3:0]  mask,
  input  logic [31:0] addr,
  input  logic [31:0] data_wr,
  output logic [31:0] data_rd,
  output logic        stall,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  o_dbg_state
);

  // Encoding is visible on o_dbg_state: 0 IDLE, 1 REQ, 2 WAIT, 3 DONE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic [31:0] r_data_rd;
  logic        r_err;
  logic        r_mem_we;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;

  logic w_start;
  logic w_busy;
  logic w_complete;
  logic w_abort;
  logic w_unused_addr_lsbs;

  assign w_busy     = (r_state == REQ) || (r_state == WAIT);
  assign w_complete = (r_state == WAIT) && mem_rvalid;
  // A completion on the last allowed cycle beats the timeout.
  assign w_abort    = w_busy && (r_cnt == TIMEOUT_LAST) && !w_complete;

  // Byte lanes are chosen by mask; the low address bits carry no information here.
  assign w_unused_addr_lsbs = ^addr[1:0];

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (!cs) begin
          if (wr || (mask != 4'b0000)) begin
            w_next  = REQ;
            w_start = 1'b1;
          end else begin
            w_next = DONE;
          end
        end
      end
      REQ: begin
        if (w_abort)      w_next = DONE;
        else if (mem_gnt) w_next = WAIT;
      end
      WAIT: begin
        if (w_complete || w_abort) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 8'd0;
      r_data_rd   <= 32'd0;
      r_err       <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= 4'b0000;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
    end else begin
      r_state <= w_next;
      r_err   <= w_abort;
      if (w_start)     r_cnt <= 8'd0;
      else if (w_busy) r_cnt <= r_cnt + 8'd1;
      if (w_start) begin
        r_mem_we    <= ~wr;
        r_mem_be    <= wr ? 4'b1111 : mask;
        r_mem_addr  <= {addr[31:2], 2'b00};
        r_mem_wdata <= data_wr;
      end
      // Stores never touch data_rd; the in-flight direction is held in r_mem_we.
      if (!r_mem_we) begin
        if (w_complete)   r_data_rd <= mem_rdata;
        else if (w_abort) r_data_rd <= ERR_RDATA;
      end
    end
  end

  assign stall       = ((r_state == IDLE) && !cs) || w_busy;
  assign mem_req     = (r_state == REQ);
  assign mem_we      = r_mem_we;
  assign mem_be      = r_mem_be;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign data_rd     = r_data_rd;
  assign err         = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Self-checking bench for dmem_bus_bridge: directed test-plan steps plus randomized
// accesses against a cycle-count/result model of the bridge.
`timescale 1ns/1ps
module tb_dmem_bus_bridge;

  localparam int unsigned TIMEOUT   = 8;
  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;
  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_WAIT   = 2'd2;
  localparam int          NEVER     = 255;

  logic        clk;
  logic        rst_n;
  logic        cs;
  logic        wr;
  logic [3:0]  mask;
  logic [31:0] addr;
  logic [31:0] data_wr;
  logic [31:0] data_rd;
  logic        stall;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  o_dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_rd;

  dmem_bus_bridge #(
    .TIMEOUT   (TIMEOUT),
    .ERR_RDATA (ERR_RDATA)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cs          (cs),
    .wr          (wr),
    .mask        (mask),
    .addr        (addr),
    .data_wr     (data_wr),
    .data_rd     (data_rd),
    .stall       (stall),
    .err         (err),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_be      (mem_be),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .o_dbg_state (o_dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Runs one LSU access. g = extra cycles before gnt, r = extra cycles before rvalid
  // (NEVER = memory does not respond). hold keeps cs low after DONE; late_rv
  // presents a stray rvalid in DONE and the following IDLE cycle.
  task automatic run_access(input bit is_store, input logic [3:0] m, input logic [31:0] a,
                            input logic [31:0] wd, input int g, input int r,
                            input logic [31:0] rd, input bit hold, input bit late_rv);
    bit is_null, completes, granted, rv_sent, done;
    int total, exp_stall, exp_req, exp_err;
    int stall_cnt, req_cnt, wait_cnt, err_cnt;
    logic [31:0] exp_rd;

    is_null   = is_store && (m == 4'b0000);
    total     = g + r + 2;
    completes = !is_null && (total <= int'(TIMEOUT));
    exp_stall = is_null ? 1 : 1 + ((total <= int'(TIMEOUT)) ? total : int'(TIMEOUT));
    exp_req   = is_null ? 0 : ((g + 1 < int'(TIMEOUT)) ? g + 1 : int'(TIMEOUT));
    exp_err   = (!is_null && !completes) ? 1 : 0;
    if (!is_store) model_rd = completes ? rd : ERR_RDATA;
    exp_q.push_back(model_rd);

    granted = 0; rv_sent = 0; done = 0;
    stall_cnt = 0; req_cnt = 0; wait_cnt = 0; err_cnt = 0;
    for (int cyc = 0; cyc < 3 * int'(TIMEOUT) && !done; cyc++) begin
      @(negedge clk);
      cs = 1'b0; wr = !is_store; mask = m; addr = a; data_wr = wd;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      #1;
      if (stall) stall_cnt++;
      else       done = 1;
      if (err) err_cnt++;
      if (mem_req) begin
        if (req_cnt == 0) begin
          check("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
          check("mem_be", {28'd0, mem_be}, {28'd0, (is_store ? m : 4'hF)});
          check("mem_we", {31'd0, mem_we}, {31'd0, is_store});
          check("mem_wdata", mem_wdata, wd);
        end
        if (req_cnt == g) begin
          mem_gnt = 1'b1;
          granted = 1;
        end
        req_cnt++;
      end else if (granted && !rv_sent) begin
        if (wait_cnt == r) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rd;
          rv_sent    = 1;
        end
        wait_cnt++;
      end
      if (done) begin
        exp_rd = exp_q.pop_front();
        check("done_data_rd", data_rd, exp_rd);
        check("done_err", {31'd0, err}, exp_err);
        if (late_rv) begin
          mem_rvalid = 1'b1;
          mem_rdata  = 32'h0000_5555;
        end
      end
    end
    check("done_reached", {31'd0, done}, 32'd1);
    check("stall_cycles", stall_cnt, exp_stall);
    check("req_cycles", req_cnt, exp_req);

    if (!hold) begin
      @(negedge clk);
      cs = 1'b1; mem_gnt = 1'b0; mem_rvalid = late_rv; mem_rdata = 32'h0000_5555;
      #1;
      if (err) err_cnt++;
      check("idle_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      mem_rvalid = 1'b0;
      #1;
      if (err) err_cnt++;
      check("err_pulses", err_cnt, exp_err);
      check("idle_data_rd", data_rd, model_rd);
      check("idle_mem_req", {31'd0, mem_req}, 32'd0);
    end
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0; cs = 1'b1; wr = 1'b1; mask = 4'h0; addr = 32'd0; data_wr = 32'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    model_rd = 32'd0;
    #12;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_be", {28'd0, mem_be}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_data_rd", data_rd, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_state", {30'd0, o_dbg_state}, {30'd0, ST_IDLE});
    @(negedge clk);
    rst_n = 1'b1;

    // Directed steps
    run_access(1'b0, 4'h0, 32'h0000_0104, 32'h0, 0, 0, 32'hA1B2_C3D4, 1'b0, 1'b0);
    run_access(1'b1, 4'b1000, 32'h0000_0203, 32'h7F00_0000, 2, 2, 32'h1234_5678, 1'b0, 1'b0);
    run_access(1'b1, 4'b0000, 32'h0000_0300, 32'hFFFF_FFFF, 0, 0, 32'h0, 1'b0, 1'b0);
    run_access(1'b0, 4'h0, 32'h0000_0400, 32'h0, NEVER, 0, 32'h0BAD_0BAD, 1'b0, 1'b1);
    run_access(1'b0, 4'h0, 32'h0000_0500, 32'h0, 1, 1, 32'h0F0F_1234, 1'b0, 1'b0);
    // Completion on the very last allowed cycle: rvalid wins over timeout
    run_access(1'b0, 4'h0, 32'h0000_0504, 32'h0, 3, 3, 32'hCAFE_0001, 1'b0, 1'b0);
    // Timeout while waiting for rvalid on a store leaves data_rd alone
    run_access(1'b1, 4'b0011, 32'h0000_0508, 32'h0000_BEEF, 2, NEVER, 32'h0, 1'b0, 1'b0);
    // Held cs through DONE: the retiring access must not replay
    run_access(1'b0, 4'h0, 32'h0000_0600, 32'h0, 0, 0, 32'h1111_2222, 1'b1, 1'b0);
    run_access(1'b0, 4'h0, 32'h0000_0604, 32'h0, 0, 1, 32'h3333_4444, 1'b0, 1'b0);

    // Async reset mid-WAIT
    @(negedge clk);
    cs = 1'b0; wr = 1'b1; mask = 4'h0; addr = 32'h0000_0700;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    #1;
    check("rstw_req", {31'd0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    check("rstw_in_wait", {30'd0, o_dbg_state}, {30'd0, ST_WAIT});
    #1;
    rst_n = 1'b0;
    #1;
    check("rstw_mem_req", {31'd0, mem_req}, 32'd0);
    check("rstw_data_rd", data_rd, 32'd0);
    check("rstw_mem_addr", mem_addr, 32'd0);
    check("rstw_state", {30'd0, o_dbg_state}, {30'd0, ST_IDLE});
    check("rstw_stall_cs0", {31'd0, stall}, 32'd1);
    cs = 1'b1;
    #1;
    check("rstw_stall_cs1", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_rd = 32'd0;
    run_access(1'b0, 4'h0, 32'h0000_0704, 32'h0, 0, 0, 32'h5A5A_A5A5, 1'b0, 1'b0);

    // Randomized accesses
    for (int n = 0; n < 40; n++) begin
      int kind, g, r;
      logic [3:0] m;
      kind = $urandom_range(0, 11);
      g = $urandom_range(0, 4);
      r = $urandom_range(0, 4);
      if (kind == 11) g = NEVER;
      if (kind == 10) r = NEVER;
      m = (kind == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      run_access(kind <= 4, m, $urandom, $urandom, g, r, $urandom, 1'b0, kind[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
